// File: rtl/spi_cmd_sequencer.sv
// SPI command sequencer: decodes command/address bytes from the SPI byte stream and
// drives auto-incrementing writes or pipelined reads on a single-beat req/ack bus.
module spi_cmd_sequencer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cs,
  input  logic [7:0] mosi,
  output logic [7:0] miso,
  output logic       bus_req,
  output logic       bus_we,
  output logic [7:0] bus_addr,
  output logic [7:0] bus_wdata,
  input  logic       bus_ack,
  input  logic [7:0] bus_rdata,
  output logic       overrun
);

  typedef enum logic [2:0] {
    S_CMD,
    S_ADDR_WR,
    S_ADDR_RD,
    S_WR_DATA,
    S_RD_DATA,
    S_STATUS,
    S_IGNORE
  } state_t;

  localparam logic [7:0] CMD_WRITE  = 8'h02;
  localparam logic [7:0] CMD_READ   = 8'h03;
  localparam logic [7:0] CMD_STATUS = 8'h05;
  localparam logic [7:0] CMD_CLEAR  = 8'h06;

  state_t     state_q;
  logic [7:0] ptr_q;
  logic [7:0] miso_q;
  logic       req_q;
  logic       we_q;
  logic [7:0] addr_q;
  logic [7:0] wdata_q;
  logic       overrun_q;

  logic       issue_ok;
  logic       ovr_set;
  logic       ovr_clr;
  logic       overrun_d;
  logic [7:0] ptr_inc_d;

  // A new beat may launch when the bus is idle or the pending beat completes now.
  assign issue_ok  = !req_q || bus_ack;
  assign ptr_inc_d = ptr_q + 8'd1;

  always_comb begin
    ovr_set = 1'b0;
    ovr_clr = 1'b0;
    if (!cs) begin
      case (state_q)
        S_CMD:     ovr_clr = (mosi == CMD_CLEAR);
        S_ADDR_RD: ovr_set = !issue_ok;
        S_WR_DATA: ovr_set = !issue_ok;
        S_RD_DATA: ovr_set = !(req_q && bus_ack);
        default:   ovr_set = 1'b0;
      endcase
    end
    // Set wins over clear.
    overrun_d = ovr_set | (overrun_q & ~ovr_clr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_CMD;
      ptr_q     <= 8'h00;
      miso_q    <= 8'h00;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= 8'h00;
      wdata_q   <= 8'h00;
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= overrun_d;
      // Completed beats retire here; an issue below overrides this on the same edge.
      if (req_q && bus_ack) begin
        req_q <= 1'b0;
      end
      if (cs) begin
        state_q <= S_CMD;
        miso_q  <= 8'h00;
      end else begin
        case (state_q)
          S_CMD: begin
            miso_q <= 8'h00;
            case (mosi)
              CMD_WRITE:  state_q <= S_ADDR_WR;
              CMD_READ:   state_q <= S_ADDR_RD;
              CMD_STATUS: begin
                state_q <= S_STATUS;
                miso_q  <= {6'b0, req_q, overrun_q};
              end
              default:    state_q <= S_IGNORE;
            endcase
          end
          S_ADDR_WR: begin
            miso_q  <= 8'h00;
            ptr_q   <= mosi;
            state_q <= S_WR_DATA;
          end
          S_ADDR_RD: begin
            miso_q  <= 8'h00;
            ptr_q   <= mosi;
            state_q <= S_RD_DATA;
            if (issue_ok) begin
              req_q  <= 1'b1;
              we_q   <= 1'b0;
              addr_q <= mosi;
            end
          end
          S_WR_DATA: begin
            miso_q <= 8'h00;
            if (issue_ok) begin
              req_q   <= 1'b1;
              we_q    <= 1'b1;
              addr_q  <= ptr_q;
              wdata_q <= mosi;
              ptr_q   <= ptr_inc_d;
            end
          end
          S_RD_DATA: begin
            // Each completed read returns its byte and prefetches the next address.
            if (req_q && bus_ack) begin
              miso_q <= bus_rdata;
              req_q  <= 1'b1;
              we_q   <= 1'b0;
              addr_q <= ptr_inc_d;
              ptr_q  <= ptr_inc_d;
            end
          end
          S_STATUS: begin
            miso_q <= miso_q;
          end
          S_IGNORE: begin
            miso_q <= 8'h00;
          end
          default: begin
            state_q <= S_CMD;
            miso_q  <= 8'h00;
          end
        endcase
      end
    end
  end

  assign miso      = miso_q;
  assign bus_req   = req_q;
  assign bus_we    = we_q;
  assign bus_addr  = addr_q;
  assign bus_wdata = wdata_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_spi_cmd_sequencer.sv
// Scoreboard bench for spi_cmd_sequencer: directed frames push expected bus beats and
// per-cycle output values; a negedge monitor pops and compares them.
module tb_spi_cmd_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cs;
  logic [7:0] mosi;
  logic [7:0] miso;
  logic       bus_req;
  logic       bus_we;
  logic [7:0] bus_addr;
  logic [7:0] bus_wdata;
  logic       bus_ack;
  logic [7:0] bus_rdata;
  logic       overrun;

  int total = 0;
  int bad   = 0;
  int tick  = 0;

  typedef struct {
    int         t;
    int         kind;
    logic [7:0] val;
  } exp_t;

  typedef struct {
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
  } bus_t;

  exp_t exp_q[$];
  bus_t bus_q[$];

  spi_cmd_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cs        (cs),
    .mosi      (mosi),
    .miso      (miso),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_ack   (bus_ack),
    .bus_rdata (bus_rdata),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  // Target memory: mem[x] = x ^ 0x5A
  assign bus_rdata = bus_addr ^ 8'h5A;

  always @(posedge clk) tick <= tick + 1;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %02h expected %02h (tick %0d)", name, act, req, tick);
    end
  endtask

  task automatic cyc(input logic c, input logic [7:0] m, input logic a);
    @(posedge clk);
    #1;
    cs      = c;
    mosi    = m;
    bus_ack = a;
  endtask

  task automatic exp_at(input int t, input int kind, input logic [7:0] v);
    exp_t e;
    e.t = t; e.kind = kind; e.val = v;
    exp_q.push_back(e);
  endtask

  task automatic exp_bus(input logic we, input logic [7:0] addr, input logic [7:0] wdata);
    bus_t b;
    b.we = we; b.addr = addr; b.wdata = wdata;
    bus_q.push_back(b);
  endtask

  // Monitor
  always @(negedge clk) begin
    if (rst_n && bus_req && bus_ack) begin
      if (bus_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_beat: got we=%0b addr=%02h wdata=%02h expected none",
                 bus_we, bus_addr, bus_wdata);
      end else begin
        bus_t b;
        b = bus_q.pop_front();
        check("beat_we", {7'b0, bus_we}, {7'b0, b.we});
        check("beat_addr", bus_addr, b.addr);
        if (b.we) check("beat_wdata", bus_wdata, b.wdata);
      end
    end
    for (int i = exp_q.size() - 1; i >= 0; i--) begin
      if (exp_q[i].t == tick) begin
        case (exp_q[i].kind)
          0:       check("miso", miso, exp_q[i].val);
          1:       check("bus_req", {7'b0, bus_req}, exp_q[i].val);
          default: check("overrun", {7'b0, overrun}, exp_q[i].val);
        endcase
        exp_q.delete(i);
      end
    end
  end

  task automatic check_reset_outputs();
    check("rst_miso", miso, 8'h00);
    check("rst_bus_req", {7'b0, bus_req}, 8'h00);
    check("rst_bus_we", {7'b0, bus_we}, 8'h00);
    check("rst_bus_addr", bus_addr, 8'h00);
    check("rst_bus_wdata", bus_wdata, 8'h00);
    check("rst_overrun", {7'b0, overrun}, 8'h00);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t0;
    rst_n   = 1'b0;
    cs      = 1'b1;
    mosi    = 8'h00;
    bus_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs();
    rst_n = 1'b1;
    cyc(1'b1, 8'h00, 1'b0);

    // Write burst, always-ack target
    cyc(1'b0, 8'h02, 1'b1); t0 = tick;
    exp_bus(1'b1, 8'h10, 8'hAA);
    exp_bus(1'b1, 8'h11, 8'hBB);
    exp_bus(1'b1, 8'h12, 8'hCC);
    exp_at(t0 + 3, 1, 8'h01);
    exp_at(t0 + 3, 0, 8'h00);
    exp_at(t0 + 6, 1, 8'h00);
    exp_at(t0 + 6, 2, 8'h00);
    cyc(1'b0, 8'h10, 1'b1);
    cyc(1'b0, 8'hAA, 1'b1);
    cyc(1'b0, 8'hBB, 1'b1);
    cyc(1'b0, 8'hCC, 1'b1);
    cyc(1'b1, 8'h00, 1'b1);
    cyc(1'b1, 8'h00, 1'b1);

    // Read burst across the 0xFF -> 0x00 wrap
    cyc(1'b0, 8'h03, 1'b1); t0 = tick;
    exp_bus(1'b0, 8'hFE, 8'h00);
    exp_bus(1'b0, 8'hFF, 8'h00);
    exp_bus(1'b0, 8'h00, 8'h00);
    exp_bus(1'b0, 8'h01, 8'h00);
    exp_at(t0 + 2, 1, 8'h01);
    exp_at(t0 + 3, 0, 8'hA4);
    exp_at(t0 + 4, 0, 8'hA5);
    exp_at(t0 + 5, 0, 8'h5A);
    exp_at(t0 + 6, 0, 8'h00);
    exp_at(t0 + 6, 1, 8'h00);
    exp_at(t0 + 6, 2, 8'h00);
    cyc(1'b0, 8'hFE, 1'b1);
    cyc(1'b0, 8'h00, 1'b1);
    cyc(1'b0, 8'h00, 1'b1);
    cyc(1'b0, 8'h00, 1'b1);
    cyc(1'b1, 8'h00, 1'b1);
    cyc(1'b1, 8'h00, 1'b1);

    // Write with a slow target; cs rises while the last beat is unacked
    cyc(1'b0, 8'h02, 1'b0); t0 = tick;
    exp_bus(1'b1, 8'h20, 8'h11);
    exp_bus(1'b1, 8'h21, 8'h33);
    exp_at(t0 + 3, 2, 8'h00);
    exp_at(t0 + 4, 2, 8'h01);
    exp_at(t0 + 5, 1, 8'h01);
    exp_at(t0 + 6, 1, 8'h01);
    exp_at(t0 + 7, 1, 8'h00);
    exp_at(t0 + 7, 2, 8'h01);
    cyc(1'b0, 8'h20, 1'b0);
    cyc(1'b0, 8'h11, 1'b0);
    cyc(1'b0, 8'h22, 1'b0);
    cyc(1'b0, 8'h33, 1'b1);
    cyc(1'b1, 8'h00, 1'b0);
    cyc(1'b1, 8'h00, 1'b1);
    cyc(1'b1, 8'h00, 1'b0);

    // Unknown command: whole frame ignored
    cyc(1'b0, 8'h99, 1'b1); t0 = tick;
    exp_at(t0 + 1, 1, 8'h00);
    exp_at(t0 + 2, 1, 8'h00);
    exp_at(t0 + 2, 0, 8'h00);
    cyc(1'b0, 8'h02, 1'b1);
    cyc(1'b1, 8'h00, 1'b1);

    // Status shows sticky overrun, then clear and re-read
    cyc(1'b0, 8'h05, 1'b1); t0 = tick;
    exp_at(t0 + 1, 0, 8'h01);
    cyc(1'b0, 8'h00, 1'b1);
    cyc(1'b1, 8'h00, 1'b1);
    cyc(1'b0, 8'h06, 1'b1); t0 = tick;
    exp_at(t0 + 1, 2, 8'h00);
    cyc(1'b1, 8'h00, 1'b1);
    cyc(1'b0, 8'h05, 1'b1); t0 = tick;
    exp_at(t0 + 1, 0, 8'h00);
    cyc(1'b0, 8'h00, 1'b1);
    cyc(1'b1, 8'h00, 1'b1);

    // Reset asserted while a write is outstanding
    cyc(1'b0, 8'h02, 1'b0); t0 = tick;
    exp_at(t0 + 3, 1, 8'h01);
    cyc(1'b0, 8'h40, 1'b0);
    cyc(1'b0, 8'h77, 1'b0);
    cyc(1'b1, 8'h00, 1'b0);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    cyc(1'b0, 8'h05, 1'b1); t0 = tick;
    exp_at(t0 + 1, 0, 8'h00);
    cyc(1'b0, 8'h00, 1'b1);
    cyc(1'b1, 8'h00, 1'b1);
    cyc(1'b0, 8'h02, 1'b1); t0 = tick;
    exp_bus(1'b1, 8'h50, 8'h66);
    exp_at(t0 + 3, 1, 8'h01);
    cyc(1'b0, 8'h50, 1'b1);
    cyc(1'b0, 8'h66, 1'b1);
    cyc(1'b1, 8'h00, 1'b1);
    cyc(1'b1, 8'h00, 1'b1);
    repeat (3) cyc(1'b1, 8'h00, 1'b0);

    check("pending_expectations", exp_q.size()[7:0], 8'h00);
    check("pending_beats", bus_q.size()[7:0], 8'h00);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_cmd_sequencer.md
# spi_cmd_sequencer

Command sequencer that sits behind the byte-wide SPI controller and turns each chip-select frame into register-bus transactions. It decodes a command byte and an address byte, then issues auto-incrementing single-beat writes or pipelined reads on a simple req/ack bus. It returns read data and status on the byte-wide MISO path. One MOSI byte is consumed per clock while `cs` is low.

## Interface
- No parameters; all widths are fixed at 8 bits.
- `clk` in 1: clock; also the SPI byte clock, one byte per cycle.
- `rst_n` in 1: asynchronous active-low reset.
- `cs` in 1: chip select, active low. High means idle / end of frame.
- `mosi` in 8: command/address/data byte, sampled on every rising edge with `cs` low.
- `miso` out 8: registered response byte.
- `bus_req` out 1: transaction request, held until acked.
- `bus_we` out 1: 1 = write, 0 = read; valid while `bus_req` is high.
- `bus_addr` out 8: transaction address.
- `bus_wdata` out 8: write data.
- `bus_ack` in 1: target accepts or completes the transaction in the same cycle.
- `bus_rdata` in 8: read data, valid when `bus_ack` is high and `bus_we` is 0.
- `overrun` out 1: sticky error flag.

## Operation
- FSM states: CMD, ADDR_WR, ADDR_RD, WR_DATA, RD_DATA, STATUS, IGNORE.
- Every state returns to CMD on any edge that samples `cs` high.
- Command byte, captured in CMD:
  - 0x02 → ADDR_WR.
  - 0x03 → ADDR_RD.
  - 0x05 → STATUS; `miso` <= {6'b0, `bus_req`, `overrun`}.
  - 0x06 → IGNORE and clear `overrun`.
  - Any other value → IGNORE.
- ADDR_*: capture the address into the pointer.
  - ADDR_RD additionally issues a read of the pointer on the same edge.
- Issue-allowed condition, evaluated in the current cycle: `!bus_req || bus_ack`.
- WR_DATA, per captured byte:
  - If issue is allowed: `bus_req`=1, `bus_we`=1, `bus_addr`=pointer, `bus_wdata`=byte, and the pointer increments.
  - If issue is not allowed: the byte is dropped, `overrun` is set, and the pointer is unchanged.
- RD_DATA, per cycle with `cs` low:
  - If `bus_req && bus_ack`: `miso` <= `bus_rdata`, and the read of pointer+1 is issued (the pointer increments).
  - Otherwise: `overrun` is set, and `miso` and the request are held.
- Pointer arithmetic is 8-bit and wraps 0xFF → 0x00.
- Handshake:
  - `bus_req` deasserts on the edge after an acked cycle unless a new transaction issues on that edge.
  - An outstanding request is never withdrawn, including when `cs` rises, until `bus_ack` is seen.
  - No new transaction issues with `cs` high.
- `miso` values:
  - 0x00 in CMD, ADDR_*, WR_DATA and IGNORE.
  - Holds its last value in STATUS and RD_DATA until the frame ends.
- Setting `overrun` takes precedence over clearing it via 0x06 in the same cycle.

## Timing
- Reset (async assert, sync release): state=CMD, `miso`=0x00, `bus_req`=0, `bus_we`=0, `bus_addr`=0x00, `bus_wdata`=0x00, pointer=0x00, `overrun`=0.
- Write frame:
  - Cycle k0 = cmd, k1 = addr A, k2 = D0.
  - `bus_req` for A/D0 is high during k3.
  - Each following byte is issued one cycle after capture.
  - Full rate requires the target to ack in the same cycle it sees `bus_req`.
- Read frame:
  - Cycle k0 = 0x03, k1 = A.
  - Read of A is requested during k2; the host sends a dummy byte.
  - D[A] is on `miso` during k3, D[A+1] during k4, and so on at one byte per cycle with zero-wait acks.
- Status: the value captured from cmd at k0 is visible on `miso` during k1.
- `cs` high for a single cycle is a complete frame boundary; the next low cycle is a command byte.

## Test plan
- Reset mid-burst: assert `rst_n`=0 while `bus_req`=1 → all outputs return to their reset values immediately, and the next frame decodes as a command.
- Write burst with an always-ack target: frame 02,10,AA,BB,CC → writes (0x10,AA), (0x11,BB), (0x12,CC) on consecutive cycles; `overrun`=0.
- Read burst from memory mem[x]=x^0x5A: frame 03,FE,00,00,00 → `miso` shows A4 (FE), A5 (FF), 5A (00, after wrap).
- Write with a target that acks every other cycle: frame 02,20,11,22,33 → 11 is written to 0x20 and 33 to 0x21; 22 is dropped; `overrun`=1.
- Status and clear: frame 05,00 → `miso`=0x01. Frame 06, then frame 05,00 → `miso`=0x00.
- `cs` rises while a write is unacked: `bus_req` stays high until `bus_ack`, then drops. Frame 99,02 → ignored, no bus traffic.
